// File: rtl/exc_ctrl_pkg.sv
// Shared types and constants for the MEM-stage exception arbiter (exc_ctrl).
// Exception codes and CP0 addresses below mirror the cp0 register/encoding map.
package exc_ctrl_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } exc_state_t;

    typedef struct packed {
        logic eret;
        logic data_ades;
        logic data_adel;
        logic ovf;
        logic trap;
        logic brk;
        logic syscall;
        logic ri;
        logic inst_adel;
    } exc_flags_t;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    // cp0 folds INST_ADD_ERR onto the AdEL ExcCode itself; it is kept distinct here
    // so cp0 can tell which address to latch into BadVAddr.
    localparam logic [31:0] EXC_NONE           = 32'h0000_0000;
    localparam logic [31:0] EXC_INT            = 32'h0000_0001;
    localparam logic [31:0] EXC_INST_ADD_ERR   = 32'h0000_0002;
    localparam logic [31:0] EXC_DATA_ADD_ERR_L = 32'h0000_0004;
    localparam logic [31:0] EXC_DATA_ADD_ERR_S = 32'h0000_0005;
    localparam logic [31:0] EXC_SYSCALL        = 32'h0000_0008;
    localparam logic [31:0] EXC_BREAK          = 32'h0000_0009;
    localparam logic [31:0] EXC_RI             = 32'h0000_000a;
    localparam logic [31:0] EXC_OVF            = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP           = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET           = 32'h0000_000e;

    // Software-writable Cause fields: IP1..IP0 (9:8), IV (23), DC (27).
    localparam logic [31:0] CAUSE_WR_MASK = 32'h0880_0300;

    function automatic logic [31:0] merge_cause(input logic [31:0] cause, input logic [31:0] wdata);
        return (cause & ~CAUSE_WR_MASK) | (wdata & CAUSE_WR_MASK);
    endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// MEM-stage / CP0 bundle seen by exc_ctrl; master = pipeline side, slave = exc_ctrl.
interface exc_ctrl_if;
    logic        valid_i;
    logic [31:0] pc_i;
    logic [31:0] mem_addr_i;
    logic        is_in_delayslot_i;
    logic        inst_adel_i;
    logic        ri_i;
    logic        syscall_i;
    logic        break_i;
    logic        trap_i;
    logic        ovf_i;
    logic        data_adel_i;
    logic        data_ades_i;
    logic        eret_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic [31:0] cp0_ebase_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_wdata_i;
    logic [31:0] excepttype_o;
    logic [31:0] current_inst_addr_o;
    logic        is_in_delayslot_o;
    logic [31:0] bad_addr_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    modport master (
        output valid_i, pc_i, mem_addr_i, is_in_delayslot_i,
               inst_adel_i, ri_i, syscall_i, break_i, trap_i, ovf_i,
               data_adel_i, data_ades_i, eret_i,
               cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_ebase_i,
               wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_wdata_i,
        input  excepttype_o, current_inst_addr_o, is_in_delayslot_o,
               bad_addr_o, flush_o, new_pc_o
    );

    modport slave (
        input  valid_i, pc_i, mem_addr_i, is_in_delayslot_i,
               inst_adel_i, ri_i, syscall_i, break_i, trap_i, ovf_i,
               data_adel_i, data_ades_i, eret_i,
               cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_ebase_i,
               wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_wdata_i,
        output excepttype_o, current_inst_addr_o, is_in_delayslot_o,
               bad_addr_o, flush_o, new_pc_o
    );
endinterface

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: fault flags + pending interrupt -> exception code and bad address.
module exc_prio_enc
    import exc_ctrl_pkg::*;
(
    input  exc_flags_t  flags_i,
    input  logic        irq_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] mem_addr_i,
    output logic [31:0] code_o,
    output logic [31:0] bad_addr_o
);

    always_comb begin
        code_o     = EXC_NONE;
        bad_addr_o = '0;
        if (irq_i) begin
            code_o = EXC_INT;
        end else if (flags_i.inst_adel) begin
            code_o     = EXC_INST_ADD_ERR;
            bad_addr_o = pc_i;
        end else if (flags_i.ri) begin
            code_o = EXC_RI;
        end else if (flags_i.syscall) begin
            code_o = EXC_SYSCALL;
        end else if (flags_i.brk) begin
            code_o = EXC_BREAK;
        end else if (flags_i.trap) begin
            code_o = EXC_TRAP;
        end else if (flags_i.ovf) begin
            code_o = EXC_OVF;
        end else if (flags_i.data_adel) begin
            code_o     = EXC_DATA_ADD_ERR_L;
            bad_addr_o = mem_addr_i;
        end else if (flags_i.data_ades) begin
            code_o     = EXC_DATA_ADD_ERR_S;
            bad_addr_o = mem_addr_i;
        end else if (flags_i.eret) begin
            code_o = EXC_ERET;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception arbiter: forwards WB CP0 writes, picks one exception, issues flush + redirect PC.
// Optional build macro EXC_VECTOR_IV_EN: interrupts with Cause.IV=1 vector to ebase + VEC_INT_OFS.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] VEC_GEN_OFS = 32'h0000_0180,
    parameter logic [31:0] VEC_INT_OFS = 32'h0000_0200
)
(
    input  logic         clk,
    input  logic         rst,
    exc_ctrl_if.slave    bus
);

    exc_state_t  state_q, state_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;

    logic [31:0] status_fwd, cause_fwd, epc_fwd;
    logic        irq;
    exc_flags_t  flags;
    logic [31:0] enc_code, enc_bad_addr;
    logic        take;
    logic        iv_sel;
    logic [31:0] target;
    logic        unused_bits;

    // The WB instruction is older than MEM, so its CP0 write must be visible now.
    always_comb begin
        status_fwd = bus.cp0_status_i;
        cause_fwd  = bus.cp0_cause_i;
        epc_fwd    = bus.cp0_epc_i;
        if (bus.wb_cp0_we_i) begin
            case (bus.wb_cp0_waddr_i)
                CP0_STATUS: status_fwd = bus.wb_cp0_wdata_i;
                CP0_CAUSE:  cause_fwd  = merge_cause(bus.cp0_cause_i, bus.wb_cp0_wdata_i);
                CP0_EPC:    epc_fwd    = bus.wb_cp0_wdata_i;
                default:    ;
            endcase
        end
    end

    assign irq = status_fwd[0] & ~status_fwd[1] & (|(cause_fwd[15:8] & status_fwd[15:8]));

    assign flags = '{
        eret:      bus.eret_i,
        data_ades: bus.data_ades_i,
        data_adel: bus.data_adel_i,
        ovf:       bus.ovf_i,
        trap:      bus.trap_i,
        brk:       bus.break_i,
        syscall:   bus.syscall_i,
        ri:        bus.ri_i,
        inst_adel: bus.inst_adel_i
    };

    exc_prio_enc u_prio_enc (
        .flags_i    (flags),
        .irq_i      (irq),
        .pc_i       (bus.pc_i),
        .mem_addr_i (bus.mem_addr_i),
        .code_o     (enc_code),
        .bad_addr_o (enc_bad_addr)
    );

    // Bubbles never trap, so a pending interrupt waits for a real instruction.
    assign take = ~rst & (state_q == RUN) & bus.valid_i & (enc_code != EXC_NONE);

    assign bus.excepttype_o        = take ? enc_code : EXC_NONE;
    assign bus.bad_addr_o          = take ? enc_bad_addr : '0;
    assign bus.current_inst_addr_o = bus.pc_i;
    assign bus.is_in_delayslot_o   = bus.is_in_delayslot_i;
    assign bus.flush_o             = flush_q;
    assign bus.new_pc_o            = new_pc_q;

`ifdef EXC_VECTOR_IV_EN
    assign iv_sel = (enc_code == EXC_INT) & cause_fwd[23];
`else
    assign iv_sel = 1'b0;
`endif

    always_comb begin
        if (enc_code == EXC_ERET) begin
            target = epc_fwd;
        end else if (iv_sel) begin
            target = bus.cp0_ebase_i + VEC_INT_OFS;
        end else begin
            target = bus.cp0_ebase_i + VEC_GEN_OFS;
        end
    end

    assign unused_bits = ^{status_fwd[31:16], status_fwd[7:2], cause_fwd[31:16], cause_fwd[7:0]};

    always_comb begin
        state_d  = take ? FLUSH : RUN;
        flush_d  = take;
        new_pc_d = take ? target : new_pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            flush_q  <= 1'b0;
            new_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            flush_q  <= flush_d;
            new_pc_q <= new_pc_d;
        end
    end

endmodule
